// File: rtl/anc_pkg.sv
// rtl/anc_pkg.sv - shared CRC constants, framer state enum and CRC byte step
// Purpose: definitions shared by the transmit framer and the receive-side checker.
// Ports: none (package).
package anc_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {IDLE, FILL, DROP, CRC, READY} anc_state_e;

  // CRC-16-CCITT, MSB-first, no reflection: fold the whole byte into the top
  // of the register, then shift out eight bits.
  function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc,
                                                   input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/anc_crc16_byte.sv
// rtl/anc_crc16_byte.sv - combinational byte-wide CRC-16-CCITT step
// Purpose: advance a running CRC by one byte in a single cycle.
// Ports: crc_in  - running CRC before the byte
//        data    - byte to fold in
//        crc_out - running CRC after the byte
module anc_crc16_byte
  import anc_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  assign crc_out = crc16_ccitt_byte(crc_in, data);

endmodule

// File: rtl/anc_tx_framer.sv
// rtl/anc_tx_framer.sv - payload byte stream to double-buffered tx_bits frame word
// Purpose: builds preamble/len/payload/CRC frames in a staging word and swaps
//          them into the active tx_bits word when mtx_ctrl has consumed it.
// Ports: clk, reset (async, active-high)
//        s_tdata/s_tvalid/s_tlast/s_tready - payload byte stream in
//        ntx_bits_cnt  - mtx_ctrl transmitted-bit counter (wrap to 0 = consumed)
//        tx_bits/tx_bits_valid/tx_nbits    - active frame word and its bit count
//        err_overflow  - one-cycle pulse when an oversized frame is dropped
//        frames_sent   - count of consumed frames
module anc_tx_framer
  import anc_pkg::*;
#(
  parameter int          TX_BITS_WIDTH = 128,
  parameter int          BIT_CNT_WIDTH = 7,
  parameter int          MAX_PAYLOAD   = 11,
  parameter logic [15:0] PREAMBLE      = 16'hAAAA
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               s_tdata,
  input  logic                     s_tvalid,
  input  logic                     s_tlast,
  output logic                     s_tready,
  input  logic [BIT_CNT_WIDTH-1:0] ntx_bits_cnt,
  output logic [TX_BITS_WIDTH-1:0] tx_bits,
  output logic                     tx_bits_valid,
  output logic [7:0]               tx_nbits,
  output logic                     err_overflow,
  output logic [15:0]              frames_sent
);

  localparam int NBYTES = TX_BITS_WIDTH / 8;
  localparam int BIW    = $clog2(NBYTES);

  anc_state_e               state, state_nxt;
  logic [TX_BITS_WIDTH-1:0] staging;
  logic [15:0]              crc, crc_in, crc_step;
  logic [7:0]               cnt;
  logic [BIT_CNT_WIDTH-1:0] ntx_d;
  logic                     accept, at_limit, consume, load, s_tready_nxt;
  logic [BIW-1:0]           pay_idx, crc_lo_idx;

  assign accept   = s_tvalid & s_tready;
  // In FILL, cnt bytes are already stored, so this accept is byte MAX_PAYLOAD+1.
  assign at_limit = (state == FILL) && (cnt == 8'(MAX_PAYLOAD));
  assign consume  = tx_bits_valid && (ntx_bits_cnt == '0) && (ntx_d != '0);
  assign load     = (state == READY) && (!tx_bits_valid || consume);

  // Byte slot after the stored payload: next payload byte in FILL, CRC high in CRC.
  assign pay_idx    = BIW'(cnt + 8'd3);
  assign crc_lo_idx = BIW'(cnt + 8'd4);

  // First byte of a frame always starts from the init value.
  assign crc_in = (state == IDLE) ? CRC16_INIT : crc;

  anc_crc16_byte u_crc (
    .crc_in  (crc_in),
    .data    (s_tdata),
    .crc_out (crc_step)
  );

  // State register; s_tready is registered so it stays low through reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      s_tready <= 1'b0;
    end else begin
      state    <= state_nxt;
      s_tready <= s_tready_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = s_tlast ? CRC : FILL;
      FILL:  if (accept) begin
               if (at_limit)     state_nxt = s_tlast ? IDLE : DROP;
               else if (s_tlast) state_nxt = CRC;
             end
      DROP:  if (accept && s_tlast) state_nxt = IDLE;
      CRC:   state_nxt = READY;
      READY: if (load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_tready_nxt = (state_nxt == IDLE) || (state_nxt == FILL) || (state_nxt == DROP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_bits       <= '0;
      tx_bits_valid <= 1'b0;
      tx_nbits      <= 8'd0;
      err_overflow  <= 1'b0;
      frames_sent   <= 16'd0;
      staging       <= '0;
      crc           <= CRC16_INIT;
      cnt           <= 8'd0;
      ntx_d         <= '0;
    end else begin
      ntx_d        <= ntx_bits_cnt;
      err_overflow <= 1'b0;

      if (consume) frames_sent <= frames_sent + 16'd1;

      if (load) begin
        tx_bits       <= staging;
        tx_nbits      <= (cnt + 8'd5) << 3;
        tx_bits_valid <= 1'b1;
      end else if (consume) begin
        tx_bits       <= '0;
        tx_bits_valid <= 1'b0;
        tx_nbits      <= 8'd0;
      end

      case (state)
        IDLE, FILL: if (accept) begin
          if (at_limit) begin
            err_overflow <= 1'b1;
            staging      <= '0;
            cnt          <= 8'd0;
            crc          <= CRC16_INIT;
          end else begin
            staging[{pay_idx, 3'b000} +: 8] <= s_tdata;
            cnt <= cnt + 8'd1;
            crc <= crc_step;
          end
        end
        DROP: if (accept && s_tlast) begin
          staging <= '0;
          cnt     <= 8'd0;
          crc     <= CRC16_INIT;
        end
        CRC: begin
          staging[15:0]                      <= PREAMBLE;
          staging[23:16]                     <= cnt;
          staging[{pay_idx, 3'b000} +: 8]    <= crc[15:8];
          staging[{crc_lo_idx, 3'b000} +: 8] <= crc[7:0];
        end
        READY: if (load) begin
          staging <= '0;
          cnt     <= 8'd0;
          crc     <= CRC16_INIT;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_anc_tx_framer.sv
// tb/tb_anc_tx_framer.sv - scoreboard bench for anc_tx_framer
module tb_anc_tx_framer;

  typedef struct {
    logic [127:0] bits;
    logic [7:0]   nbits;
  } frame_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   s_tdata;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tready;
  logic [6:0]   ntx_bits_cnt;
  logic [127:0] tx_bits;
  logic         tx_bits_valid;
  logic [7:0]   tx_nbits;
  logic         err_overflow;
  logic [15:0]  frames_sent;

  int     checks = 0;
  int     failures = 0;
  frame_t exp_q[$];
  logic [7:0] pl [16];
  logic [127:0] frame_a;

  anc_tx_framer dut (
    .clk           (clk),
    .reset         (reset),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tlast       (s_tlast),
    .s_tready      (s_tready),
    .ntx_bits_cnt  (ntx_bits_cnt),
    .tx_bits       (tx_bits),
    .tx_bits_valid (tx_bits_valid),
    .tx_nbits      (tx_nbits),
    .err_overflow  (err_overflow),
    .frames_sent   (frames_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bit-serial reference CRC and frame builder over pl[0..len-1].
  function automatic frame_t build_frame(input int len);
    frame_t f;
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    f.bits = '0;
    f.bits[15:0]  = 16'hAAAA;
    f.bits[23:16] = 8'(len);
    for (int i = 0; i < len; i++) begin
      f.bits[8*(i+3) +: 8] = pl[i];
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ pl[i][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    f.bits[8*(len+3) +: 8] = c[15:8];
    f.bits[8*(len+4) +: 8] = c[7:0];
    f.nbits = 8'(8 * (len + 5));
    return f;
  endfunction

  // Monitor: every new active word is popped against the scoreboard.
  logic         prev_valid = 1'b0;
  logic [127:0] prev_bits = '0;
  always @(negedge clk) begin
    frame_t f;
    if (reset) begin
      prev_valid <= 1'b0;
      prev_bits  <= '0;
    end else begin
      if (tx_bits_valid && (!prev_valid || tx_bits !== prev_bits)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_load: got %h expected no load", tx_bits);
        end else begin
          f = exp_q.pop_front();
          chk("sb_bits", tx_bits, f.bits);
          chk("sb_nbits", 128'(tx_nbits), 128'(f.nbits));
        end
      end
      prev_valid <= tx_bits_valid;
      prev_bits  <= tx_bits;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input bit last);
    int n;
    s_tdata = d; s_tvalid = 1'b1; s_tlast = last;
    n = 0;
    while (!s_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) begin
      checks++;
      failures++;
      $display("FAIL tready_timeout: got s_tready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit push);
    if (push) exp_q.push_back(build_frame(len));
    for (int i = 0; i < len; i++) send_byte(pl[i], i == len - 1);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!tx_bits_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, 128'(tx_bits_valid), 128'(1));
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_tx_bits", tx_bits, '0);
    chk("rst_valid_tready_err", {tx_bits_valid, s_tready, err_overflow}, '0);
    chk("rst_nbits_sent", {tx_nbits, frames_sent}, '0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic sweep(output bit tready_seen);
    tready_seen = 1'b0;
    for (int v = 1; v <= 111; v++) begin
      @(negedge clk);
      ntx_bits_cnt = 7'(v);
      if (s_tready) tready_seen = 1'b1;
    end
    @(negedge clk);
    if (s_tready) tready_seen = 1'b1;
    ntx_bits_cnt = 7'd0;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    reset = 1'b1; s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0; ntx_bits_cnt = 7'd0;
    #1;
    chk("init_outputs", {tx_bits_valid, s_tready, err_overflow, tx_nbits, frames_sent}, '0);
    chk("init_tx_bits", tx_bits, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_tready", 128'(s_tready), 128'(1));

    // "123456789": CRC 0x29B1, load two cycles after tlast.
    for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
    send_frame(9, 1'b1);
    chk("lat_n", 128'(tx_bits_valid), 128'(0));
    @(negedge clk);
    chk("lat_n1", 128'(tx_bits_valid), 128'(0));
    @(negedge clk);
    chk("lat_n2", 128'(tx_bits_valid), 128'(1));
    chk("t1_pre_len_b0", 128'(tx_bits[31:0]), 128'(32'h3109AAAA));
    chk("t1_crc", 128'({tx_bits[103:96], tx_bits[111:104]}), 128'(16'h29B1));
    chk("t1_upper_zero", 128'(tx_bits[127:112]), 128'(0));
    chk("t1_nbits", 128'(tx_nbits), 128'(112));

    // Single-byte frame.
    do_reset();
    pl[0] = 8'h5A;
    send_frame(1, 1'b1);
    wait_valid("t2_valid");
    chk("t2_nbits", 128'(tx_nbits), 128'(48));
    chk("t2_len", 128'(tx_bits[23:16]), 128'(1));
    chk("t2_upper_zero", 128'(tx_bits[127:48]), 128'(0));

    // Overflow: 12 bytes without tlast then a 13th with tlast.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      send_byte(8'h80 + 8'(i), i == 12);
      chk($sformatf("ovf_err_b%0d", i + 1), 128'(err_overflow), 128'(i == 11));
    end
    repeat (5) @(negedge clk);
    chk("ovf_no_load", 128'(tx_bits_valid), 128'(0));
    pl[0] = 8'hC3; pl[1] = 8'h3C; pl[2] = 8'h00;
    send_frame(3, 1'b1);
    wait_valid("ovf_next_valid");

    // Frame A active, frame B staged, swap on the counter wrap.
    do_reset();
    pl[0] = 8'h11; pl[1] = 8'h22;
    send_frame(2, 1'b1);
    wait_valid("swap_a_valid");
    frame_a = tx_bits;
    for (int i = 0; i < 4; i++) pl[i] = 8'hF0 - 8'(i);
    send_frame(4, 1'b1);
    repeat (3) @(negedge clk);
    chk("swap_b_staged_tready", 128'(s_tready), 128'(0));
    chk("swap_a_held", tx_bits, frame_a);
    sweep(seen);
    chk("swap_tready_low", 128'(seen), 128'(0));
    chk("swap_valid_kept", 128'(tx_bits_valid), 128'(1));
    chk("swap_b_nbits", 128'(tx_nbits), 128'(72));
    chk("swap_frames_sent", 128'(frames_sent), 128'(1));

    // Frame A active, nothing staged, counter wraps.
    do_reset();
    pl[0] = 8'h7E;
    send_frame(1, 1'b1);
    wait_valid("drain_valid");
    sweep(seen);
    chk("drain_bits", tx_bits, '0);
    chk("drain_valid_nbits", {tx_bits_valid, tx_nbits}, '0);
    chk("drain_frames_sent", 128'(frames_sent), 128'(1));
    sweep(seen);
    chk("idle_cnt_ignored", 128'(frames_sent), 128'(1));

    // Reset mid-FILL with a frame active, then a fresh 2-byte frame.
    do_reset();
    pl[0] = 8'h01;
    send_frame(1, 1'b1);
    wait_valid("midrst_prior_valid");
    for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i), 1'b0);
    do_reset();
    pl[0] = 8'hDE; pl[1] = 8'hAD;
    send_frame(2, 1'b1);
    wait_valid("midrst_valid");
    chk("midrst_len", 128'(tx_bits[23:16]), 128'(2));

    repeat (3) @(negedge clk);
    chk("sb_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/anc_tx_framer.md
Name: anc_tx_framer

Overview:
Upstream feeder for mtx_ctrl. It accepts payload bytes on a valid/ready byte stream and builds a frame: preamble, length, payload, then CRC-16. The frame is packed LSB-first into a TX_BITS_WIDTH word that drives mtx_ctrl.tx_bits. The block double-buffers: a staging frame is built while the active word is held stable. The staged frame is swapped in when mtx_ctrl signals consumption through an ntx_bits_cnt wrap.

Parameters:
TX_BITS_WIDTH, 128, width of the tx_bits word; must be ≥ 8*(MAX_PAYLOAD+5).
BIT_CNT_WIDTH, 7, width of ntx_bits_cnt from mtx_ctrl.
MAX_PAYLOAD, 11, maximum payload bytes per frame.
PREAMBLE, 16'hAAAA, 16-bit preamble placed at bits [15:0].

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
s_tdata  in  8  payload byte
s_tvalid  in  1  byte valid
s_tlast  in  1  last byte of the frame
s_tready  out  1  byte accepted when s_tvalid & s_tready
ntx_bits_cnt  in  BIT_CNT_WIDTH  mtx_ctrl transmitted-bit counter
tx_bits  out  TX_BITS_WIDTH  active frame word to mtx_ctrl
tx_bits_valid  out  1  active word holds an unsent frame
tx_nbits  out  8  valid bit count of active frame = 8*(len+5)
err_overflow  out  1  one-cycle pulse when a frame is dropped for exceeding MAX_PAYLOAD
frames_sent  out  16  count of consumed frames, wraps at 16'hFFFF→0

Behaviour:
- Reset (async) clears:
  - outputs: tx_bits=0, tx_bits_valid=0, tx_nbits=0, err_overflow=0, frames_sent=0, s_tready=0
  - internal: staging=0, crc=16'hFFFF, byte count=0, ntx_bits_cnt_d=0, state=IDLE.
- Reset mid-frame discards all partial and staged data. No output glitch before the first post-reset clock edge.
- Frame layout: frame byte k occupies bits [8k+7:8k].
  - Bytes 0–1: PREAMBLE (low byte first).
  - Byte 2: len.
  - Bytes 3..len+2: payload, in arrival order.
  - Byte len+3: CRC[15:8]; byte len+4: CRC[7:0].
  - All higher bits are 0.
- CRC: CRC-16-CCITT, poly 0x1021, init 0xFFFF, MSB-first, no reflection, no xorout. Computed over payload bytes only. Byte-wide combinational update, one byte per cycle.
- States:
  - IDLE: s_tready=1. First accepted byte goes to FILL. If that byte has tlast, go straight to CRC.
  - FILL: s_tready=1. Each accepted byte is written at the next payload slot, count increments, CRC updates.
    - Accepted byte with tlast and count ≤ MAX_PAYLOAD → CRC.
    - Accepting byte number MAX_PAYLOAD+1 → err_overflow pulse, then DROP (or IDLE if that byte carries tlast).
  - DROP: s_tready=1. Bytes are discarded; tlast → IDLE. Staging is cleared on exit.
  - CRC: s_tready=0. Writes len and both CRC bytes into staging (1 cycle), then → READY.
  - READY: s_tready=0. Waits for a load; on load, staging is cleared and state → IDLE.
- Consume event: tx_bits_valid & (ntx_bits_cnt==0) & (ntx_bits_cnt_d!=0), where ntx_bits_cnt_d is ntx_bits_cnt registered. On consume, frames_sent increments.
- Load condition: state==READY & (!tx_bits_valid | consume).
  - On load: tx_bits←staging, tx_nbits←8*(len+5), tx_bits_valid←1.
  - Consume and load in the same cycle → load wins; tx_bits_valid stays 1.
- Consume without load: tx_bits←0, tx_bits_valid←0, tx_nbits←0. mtx_ctrl then idles on zero bits.
- Latency: tlast accepted at edge N → READY at N+1 → tx_bits updated at N+2 when the active word is empty.
- Back-pressure: s_tready is low from the CRC state until the load. At most one frame is staged plus one active.
- A change of ntx_bits_cnt while tx_bits_valid=0 has no effect.

Decomposition:
- Shared package anc_pkg holds:
  - CRC16_POLY=16'h1021, CRC16_INIT=16'hFFFF
  - the state enum {IDLE,FILL,DROP,CRC,READY}
  - the function crc16_ccitt_byte(crc, byte).
- One natural sub-module, anc_crc16_byte: combinational byte-wide CRC step, reusable by the receive-side checker.

Test Plan:
- Payload "123456789" (9 bytes, tlast on the last byte), ntx_bits_cnt held 0:
  - CRC=0x29B1; tx_bits[15:0]=16'hAAAA, [23:16]=8'h09, [31:24]=8'h31, byte 12=8'h29, byte 13=8'hB1, bits above 111 are 0
  - tx_nbits=112; tx_bits_valid rises 2 cycles after tlast.
- Single byte 8'h5A with tlast: len=1, tx_nbits=48, bits [127:48]=0.
- 12 bytes without tlast, then a 13th byte with tlast:
  - err_overflow pulses exactly once, on the 12th byte
  - no load; tx_bits_valid stays 0
  - next valid frame loads normally.
- Frame A active and frame B staged; ntx_bits_cnt sweeps 0→111→0:
  - s_tready=0 until the wrap
  - at the wrap, tx_bits becomes B the next cycle, tx_bits_valid stays 1, frames_sent=1.
- Frame A active, nothing staged, ntx_bits_cnt wraps: tx_bits→0, tx_bits_valid→0, frames_sent=1.
- Assert reset for 3 cycles mid-FILL (5 bytes in):
  - all outputs return to reset values asynchronously
  - a subsequent 2-byte frame produces len=2 with a fresh CRC init of 0xFFFF.
